// File: rtl/matrix_operand_loader_if.sv
// Byte-stream in, packed 5x5 operand pair out, for the matrix add/sub stages.
// Signal names are from the loader's point of view.
interface matrix_operand_loader_if #(
    parameter int DATA_W = 8,
    parameter int DIM    = 5
);
    localparam int BUS_W = DIM * DIM * DATA_W;

    logic              start;
    logic [2:0]        size;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [BUS_W-1:0]  matrix_a;
    logic [BUS_W-1:0]  matrix_b;
    logic              operands_valid;
    logic              ack;
    logic              busy;

    modport master (
        output start, size, in_data, in_valid, ack,
        input  in_ready, matrix_a, matrix_b, operands_valid, busy
    );

    modport slave (
        input  start, size, in_data, in_valid, ack,
        output in_ready, matrix_a, matrix_b, operands_valid, busy
    );
endinterface

// File: rtl/matrix_operand_loader.sv
// Loads an n x n matrix A and then B, one byte per handshake, into row-major
// DIM x DIM buses and holds them with operands_valid until acknowledged.
module matrix_operand_loader #(
    parameter int DATA_W = 8,
    parameter int DIM    = 5
) (
    input logic                     clk,
    input logic                     rst,
    matrix_operand_loader_if.slave  bus
);
    localparam int BUS_W = DIM * DIM * DATA_W;

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, READY} state_t;

    state_t           state_q, state_d;
    logic [2:0]       n_q, n_d;
    logic [2:0]       row_q, row_d;
    logic [2:0]       col_q, col_d;
    logic [BUS_W-1:0] mat_a_q, mat_a_d;
    logic [BUS_W-1:0] mat_b_q, mat_b_d;

    logic       begin_load;
    logic       last_col;
    logic       last_row;
    logic [2:0] size_fix;
    logic [7:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            mat_a_q <= '0;
            mat_b_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        row_d   = row_q;
        col_d   = col_q;
        mat_a_d = mat_a_q;
        mat_b_d = mat_b_q;

        // Out-of-range sizes fall back to the full matrix
        size_fix   = (bus.size < 3'd2 || int'(bus.size) > DIM) ? 3'(DIM) : bus.size;
        begin_load = bus.start && (state_q == IDLE || state_q == READY);
        last_col   = (col_q == n_q - 3'd1);
        last_row   = (row_q == n_q - 3'd1);
        idx        = 8'(int'(row_q) * DIM + int'(col_q));

        if (begin_load) begin
            n_d     = size_fix;
            mat_a_d = '0;
            mat_b_d = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = LOAD_A;
        end else begin
            case (state_q)
                LOAD_A, LOAD_B: begin
                    if (bus.in_valid) begin
                        if (state_q == LOAD_A) mat_a_d[idx*DATA_W +: DATA_W] = bus.in_data;
                        else                   mat_b_d[idx*DATA_W +: DATA_W] = bus.in_data;
                        if (last_col) begin
                            col_d = '0;
                            if (last_row) begin
                                row_d   = '0;
                                state_d = (state_q == LOAD_A) ? LOAD_B : READY;
                            end else begin
                                row_d = row_q + 3'd1;
                            end
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                    end
                end
                READY:   if (bus.ack) state_d = IDLE;
                default: ;
            endcase
        end
    end

    assign bus.in_ready       = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign bus.busy           = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign bus.operands_valid = (state_q == READY);
    assign bus.matrix_a       = mat_a_q;
    assign bus.matrix_b       = mat_b_q;
endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: driver pushes expected operand
// pairs at start, a negedge monitor pops and compares when operands_valid rises.
module tb_matrix_operand_loader;
    localparam int DATA_W = 8;
    localparam int DIM    = 5;
    localparam int BUS_W  = DIM * DIM * DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_operand_loader_if #(.DATA_W(DATA_W), .DIM(DIM)) dif();

    matrix_operand_loader #(.DATA_W(DATA_W), .DIM(DIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    typedef struct {
        logic [BUS_W-1:0] a;
        logic [BUS_W-1:0] b;
        int               start_cyc;
        int               delta;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic vprev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Row-major placement of n*n consecutive bytes into the DIM x DIM bus
    function automatic logic [BUS_W-1:0] model(input int n, input int base);
        logic [BUS_W-1:0] m;
        m = '0;
        for (int i = 0; i < n * n; i++)
            m[((i / n) * DIM + (i % n)) * DATA_W +: DATA_W] = 8'(base + i);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input int sz, input int n, input int abase, input int bbase,
                               input int gap, input bit with_ack);
        exp_t e;
        e.a         = model(n, abase);
        e.b         = model(n, bbase);
        e.delta     = 2 * n * n * (gap + 1) - gap;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        dif.start = 1'b1;
        dif.size  = 3'(sz);
        dif.ack   = with_ack;
        tick();
        dif.start = 1'b0;
        dif.ack   = 1'b0;
    endtask

    task automatic stream(input string name, input int n, input int abase, input int bbase,
                          input int gap, input bit pulse);
        bit rdy_ok;
        rdy_ok = 1'b1;
        for (int i = 0; i < 2 * n * n; i++) begin
            dif.in_valid = 1'b1;
            dif.in_data  = (i < n * n) ? 8'(abase + i) : 8'(bbase + i - n * n);
            if (!dif.in_ready) rdy_ok = 1'b0;
            tick();
            if (i != 2 * n * n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    dif.in_valid = 1'b0;
                    if (!dif.in_ready) rdy_ok = 1'b0;
                    if (pulse && i == 10) begin
                        dif.start = 1'b1;
                        dif.size  = 3'd2;
                    end
                    tick();
                    dif.start = 1'b0;
                end
            end
        end
        dif.in_valid = 1'b0;
        chk({name, "_in_ready_held"}, BUS_W'(rdy_ok), BUS_W'(1'b1));
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!dif.operands_valid && k < 300) begin
            tick();
            k++;
        end
        checks++;
        if (!dif.operands_valid) begin
            errors++;
            $display("FAIL %s_valid_timeout: got 0 expected 1", name);
        end
    endtask

    task automatic do_ack();
        dif.ack = 1'b1;
        tick();
        dif.ack = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (dif.operands_valid && !vprev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got 1 expected 0");
            end else begin
                e = sb.pop_front();
                chk("mon_matrix_a", dif.matrix_a, e.a);
                chk("mon_matrix_b", dif.matrix_b, e.b);
                chk("mon_latency", BUS_W'(cyc - e.start_cyc), BUS_W'(e.delta));
            end
        end
        vprev = dif.operands_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BUS_W-1:0] ha;
        logic [BUS_W-1:0] hb;

        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.size     = 3'd0;
        dif.in_data  = '0;
        dif.in_valid = 1'b0;
        dif.ack      = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", BUS_W'(dif.in_ready), '0);
        chk("rst_busy", BUS_W'(dif.busy), '0);
        chk("rst_valid", BUS_W'(dif.operands_valid), '0);
        chk("rst_matrix_a", dif.matrix_a, '0);
        chk("rst_matrix_b", dif.matrix_b, '0);
        rst = 1'b0;
        tick();

        // Full 5x5 load, bytes 1..50 back to back
        issue_start(5, 5, 1, 26, 0, 1'b0);
        stream("s1", 5, 1, 26, 0, 1'b0);
        wait_valid("s1");
        chk("s1_a_first", BUS_W'(dif.matrix_a[7:0]), BUS_W'(8'd1));
        chk("s1_a_last", BUS_W'(dif.matrix_a[199:192]), BUS_W'(8'd25));
        chk("s1_b_first", BUS_W'(dif.matrix_b[7:0]), BUS_W'(8'd26));
        chk("s1_b_last", BUS_W'(dif.matrix_b[199:192]), BUS_W'(8'd50));
        do_ack();

        // 2x2 with padding
        issue_start(2, 2, 'h11, 'h21, 0, 1'b0);
        stream("s2", 2, 'h11, 'h21, 0, 1'b0);
        wait_valid("s2");
        ha = '0; ha[7:0] = 8'h11; ha[15:8] = 8'h12; ha[47:40] = 8'h13; ha[55:48] = 8'h14;
        hb = '0; hb[7:0] = 8'h21; hb[15:8] = 8'h22; hb[47:40] = 8'h23; hb[55:48] = 8'h24;
        chk("s2_a_hand", dif.matrix_a, ha);
        chk("s2_b_hand", dif.matrix_b, hb);
        do_ack();

        // in_valid toggling with a start pulse mid-load
        issue_start(5, 5, 1, 26, 1, 1'b0);
        stream("s3", 5, 1, 26, 1, 1'b1);
        wait_valid("s3");
        tick();
        chk("s3_hold_valid", BUS_W'(dif.operands_valid), BUS_W'(1'b1));
        do_ack();
        chk("ack_valid_low", BUS_W'(dif.operands_valid), '0);
        chk("ack_busy_low", BUS_W'(dif.busy), '0);
        chk("ack_a_held", dif.matrix_a, model(5, 1));
        chk("ack_b_held", dif.matrix_b, model(5, 26));

        // Restart with size 3: buses cleared on start
        issue_start(3, 3, 'h40, 'h60, 0, 1'b0);
        chk("s4_a_cleared", dif.matrix_a, '0);
        chk("s4_b_cleared", dif.matrix_b, '0);
        chk("s4_busy", BUS_W'(dif.busy), BUS_W'(1'b1));
        stream("s4", 3, 'h40, 'h60, 0, 1'b0);
        wait_valid("s4");
        do_ack();

        // Reset after 10 A transfers discards the partial load
        dif.start = 1'b1;
        dif.size  = 3'd5;
        tick();
        dif.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dif.in_valid = 1'b1;
            dif.in_data  = 8'(8'hc0 + i);
            tick();
        end
        dif.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", BUS_W'(dif.in_ready), '0);
        chk("mid_rst_busy", BUS_W'(dif.busy), '0);
        chk("mid_rst_valid", BUS_W'(dif.operands_valid), '0);
        chk("mid_rst_matrix_a", dif.matrix_a, '0);
        chk("mid_rst_matrix_b", dif.matrix_b, '0);
        tick();
        chk("mid_rst_idle_in_ready", BUS_W'(dif.in_ready), '0);

        // size=7 behaves as 5
        issue_start(7, 5, 'h81, 'ha0, 0, 1'b0);
        stream("s6", 5, 'h81, 'ha0, 0, 1'b0);
        wait_valid("s6");

        // start and ack together in READY: start wins
        issue_start(2, 2, 'h31, 'h41, 0, 1'b1);
        chk("s7_valid_low", BUS_W'(dif.operands_valid), '0);
        chk("s7_busy", BUS_W'(dif.busy), BUS_W'(1'b1));
        chk("s7_a_cleared", dif.matrix_a, '0);
        stream("s7", 2, 'h31, 'h41, 0, 1'b0);
        wait_valid("s7");
        do_ack();

        tick();
        tick();
        chk("scoreboard_drained", BUS_W'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
